palette_bank: RTL and testbench

Programmable, multi-bank successor to the fixed 4-bit sprite/background palettes. It holds NUM_BANKS palettes of 2^IDX_W 24-bit RGB entries, all writable at run time. It resolves one pixel lookup per cycle through a 2-stage pipeline, flags the transparent index, and applies a frame-ticked global fade to or from black. It sits between the sprite/background index generators and the VGA colour outputs.

---
 rtl/palette_bank_if.sv | 41 ++++
 rtl/palette_bank.sv | 209 ++++++++++++++++++++
 tb/tb_palette_bank.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/palette_bank_if.sv
// Pixel-lookup, palette-write and fade-control bundle for palette_bank.
// The master modport is the requester side; the slave modport is the palette itself.
interface palette_bank_if #(
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned BANK_W = 2
);
  logic              wr_en;
  logic [BANK_W-1:0] wr_bank;
  logic [IDX_W-1:0]  wr_idx;
  logic [23:0]       wr_rgb;

  logic              pix_valid;
  logic [BANK_W-1:0] pix_bank;
  logic [IDX_W-1:0]  pix_idx;

  logic              frame_tick;
  logic              fade_start;
  logic              fade_dir;

  logic              out_valid;
  logic [7:0]        Red;
  logic [7:0]        Green;
  logic [7:0]        Blue;
  logic              out_transparent;
  logic              fade_busy;
  logic [3:0]        fade_level;

  modport master (
    output wr_en, wr_bank, wr_idx, wr_rgb,
    output pix_valid, pix_bank, pix_idx,
    output frame_tick, fade_start, fade_dir,
    input  out_valid, Red, Green, Blue, out_transparent, fade_busy, fade_level
  );

  modport slave (
    input  wr_en, wr_bank, wr_idx, wr_rgb,
    input  pix_valid, pix_bank, pix_idx,
    input  frame_tick, fade_start, fade_dir,
    output out_valid, Red, Green, Blue, out_transparent, fade_busy, fade_level
  );
endinterface

// File: rtl/palette_bank.sv
// Multi-bank run-time-writable RGB palette with pipelined lookup,
// transparent-index flag and a frame-ticked global fade to/from black.
module palette_bank #(
  parameter int unsigned IDX_W      = 4,
  parameter int unsigned NUM_BANKS  = 3,
  parameter int unsigned BANK_W     = 2,
  parameter int unsigned TRANSP_IDX = 0,
  parameter int unsigned FADE_DIV   = 4
) (
  input logic           Clk,
  input logic           Reset,
  palette_bank_if.slave bus
);

  localparam int unsigned DEPTH   = 1 << IDX_W;
  localparam int unsigned CNT_W   = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [3:0]  LVL_MAX = 4'd8;
  localparam logic [3:0]  LVL_MIN = 4'd0;

  typedef enum logic {
    IDLE,
    FADING
  } state_t;

  logic [23:0] mem [NUM_BANKS][DEPTH];

  logic        wr_ok;
  logic [23:0] rd_rgb;
  logic        rd_transp;

  logic        s1_valid;
  logic [23:0] s1_rgb;
  logic        s1_transp;
  logic [3:0]  s1_level;

  logic        s2_valid;
  logic [7:0]  s2_r;
  logic [7:0]  s2_g;
  logic [7:0]  s2_b;
  logic        s2_transp;

  logic        out_valid_q;
  logic [7:0]  red_q;
  logic [7:0]  green_q;
  logic [7:0]  blue_q;
  logic        transp_q;

  state_t      state;
  state_t      state_nxt;
  logic [CNT_W-1:0] tick_cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [3:0]  level_q;
  logic [3:0]  level_nxt;
  logic        dir_up;
  logic        dir_nxt;
  logic [3:0]  target;
  logic        busy_q;

  // Channel scale: (c * level) >> 3, level 8 is unity, truncating.
  function automatic logic [7:0] scale(input logic [7:0] c, input logic [3:0] lvl);
    logic [11:0] prod;
    prod  = 12'(c) * 12'(lvl);
    scale = 8'(prod >> 3);
  endfunction

  always_comb begin
    wr_ok = bus.wr_en && (32'(bus.wr_bank) < NUM_BANKS);
  end

  // Palette storage; out-of-range bank writes are dropped.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int b = 0; b < int'(NUM_BANKS); b++) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          mem[b][i] <= 24'h000000;
        end
      end
    end else if (wr_ok) begin
      mem[bus.wr_bank][bus.wr_idx] <= bus.wr_rgb;
    end
  end

  // Combinational read sees pre-edge contents, so a same-cycle write returns the old value.
  always_comb begin
    rd_rgb    = 24'h000000;
    rd_transp = 1'b0;
    if (32'(bus.pix_bank) < NUM_BANKS) begin
      rd_rgb    = mem[bus.pix_bank][bus.pix_idx];
      rd_transp = (32'(bus.pix_idx) == TRANSP_IDX);
    end
  end

  // Stage 1: capture entry, transparency and the fade level in force at this edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_valid  <= 1'b0;
      s1_rgb    <= 24'h000000;
      s1_transp <= 1'b0;
      s1_level  <= LVL_MAX;
    end else begin
      s1_valid <= bus.pix_valid;
      if (bus.pix_valid) begin
        s1_rgb    <= rd_rgb;
        s1_transp <= rd_transp;
        s1_level  <= level_q;
      end
    end
  end

  // Stage 2: apply the fade scale per channel.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s2_valid  <= 1'b0;
      s2_r      <= 8'h00;
      s2_g      <= 8'h00;
      s2_b      <= 8'h00;
      s2_transp <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_r      <= scale(s1_rgb[23:16], s1_level);
        s2_g      <= scale(s1_rgb[15:8], s1_level);
        s2_b      <= scale(s1_rgb[7:0], s1_level);
        s2_transp <= s1_transp;
      end
    end
  end

  // Output register; colour and transparency hold while no pixel is presented.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      out_valid_q <= 1'b0;
      red_q       <= 8'h00;
      green_q     <= 8'h00;
      blue_q      <= 8'h00;
      transp_q    <= 1'b0;
    end else begin
      out_valid_q <= s2_valid;
      if (s2_valid) begin
        red_q    <= s2_r;
        green_q  <= s2_g;
        blue_q   <= s2_b;
        transp_q <= s2_transp;
      end
    end
  end

  // Fade FSM state register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      level_q  <= LVL_MAX;
      dir_up   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      tick_cnt <= cnt_nxt;
      level_q  <= level_nxt;
      dir_up   <= dir_nxt;
      busy_q   <= (state_nxt == FADING);
    end
  end

  // Fade FSM next state; a tick arriving with the start pulse is not counted.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = tick_cnt;
    level_nxt = level_q;
    dir_nxt   = dir_up;
    target    = LVL_MIN;
    case (state)
      IDLE: begin
        if (bus.fade_start) begin
          target = bus.fade_dir ? LVL_MAX : LVL_MIN;
          if (level_q != target) begin
            dir_nxt   = bus.fade_dir;
            cnt_nxt   = '0;
            state_nxt = FADING;
          end
        end
      end
      FADING: begin
        target = dir_up ? LVL_MAX : LVL_MIN;
        if (bus.frame_tick) begin
          if (tick_cnt == CNT_W'(FADE_DIV - 1)) begin
            cnt_nxt   = '0;
            level_nxt = dir_up ? (level_q + 4'd1) : (level_q - 4'd1);
            if (level_nxt == target) begin
              state_nxt = IDLE;
            end
          end else begin
            cnt_nxt = tick_cnt + CNT_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.out_valid       = out_valid_q;
  assign bus.Red             = red_q;
  assign bus.Green           = green_q;
  assign bus.Blue            = blue_q;
  assign bus.out_transparent = transp_q;
  assign bus.fade_busy       = busy_q;
  assign bus.fade_level      = level_q;

endmodule

// File: tb/tb_palette_bank.sv
// Directed bench for palette_bank: write/lookup timing, read-during-write,
// transparency, bank range, fade down/up and reset abort.
module tb_palette_bank;
  logic Clk;
  logic Reset;
  int   total;
  int   bad;

  palette_bank_if #(.IDX_W(4), .BANK_W(2)) bus ();

  palette_bank #(
    .IDX_W(4), .NUM_BANKS(3), .BANK_W(2), .TRANSP_IDX(0), .FADE_DIV(4)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .bus(bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wr_en      = 1'b0;
    bus.wr_bank    = '0;
    bus.wr_idx     = '0;
    bus.wr_rgb     = '0;
    bus.pix_valid  = 1'b0;
    bus.pix_bank   = '0;
    bus.pix_idx    = '0;
    bus.frame_tick = 1'b0;
    bus.fade_start = 1'b0;
    bus.fade_dir   = 1'b0;
  endtask

  task automatic write(input logic [1:0] b, input logic [3:0] i, input logic [23:0] rgb);
    bus.wr_en = 1'b1; bus.wr_bank = b; bus.wr_idx = i; bus.wr_rgb = rgb;
    step();
    bus.wr_en = 1'b0;
  endtask

  task automatic lookup(input logic [1:0] b, input logic [3:0] i,
                        output logic [23:0] rgb, output logic tr, output logic vld);
    bus.pix_valid = 1'b1; bus.pix_bank = b; bus.pix_idx = i;
    step();
    bus.pix_valid = 1'b0;
    step();
    step();
    rgb = {bus.Red, bus.Green, bus.Blue};
    tr  = bus.out_transparent;
    vld = bus.out_valid;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      bus.frame_tick = 1'b1;
      step();
    end
    bus.frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    Reset = 1'b1;
    step();
    step();
    Reset = 1'b0;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", bus.out_valid); end
    total++; if ({bus.Red, bus.Green, bus.Blue} !== 24'h000000) begin bad++; $display("FAIL rst_rgb got=%h exp=000000", {bus.Red, bus.Green, bus.Blue}); end
    total++; if (bus.out_transparent !== 1'b0) begin bad++; $display("FAIL rst_transp got=%b exp=0", bus.out_transparent); end
    total++; if (bus.fade_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", bus.fade_busy); end
    total++; if (bus.fade_level !== 4'd8) begin bad++; $display("FAIL rst_level got=%0d exp=8", bus.fade_level); end
  endtask

  task automatic test_write_lookup();
    write(2'd1, 4'd5, 24'hF8A0E0);
    step();
    bus.pix_valid = 1'b1; bus.pix_bank = 2'd1; bus.pix_idx = 4'd5;
    step();
    bus.pix_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL lat_n got=%b exp=0", bus.out_valid); end
    step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL lat_n1 got=%b exp=0", bus.out_valid); end
    step();
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL lat_n2 got=%b exp=1", bus.out_valid); end
    total++; if ({bus.Red, bus.Green, bus.Blue} !== 24'hF8A0E0) begin bad++; $display("FAIL wr_rgb got=%h exp=f8a0e0", {bus.Red, bus.Green, bus.Blue}); end
    total++; if (bus.out_transparent !== 1'b0) begin bad++; $display("FAIL wr_transp got=%b exp=0", bus.out_transparent); end
    step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL drop_valid got=%b exp=0", bus.out_valid); end
    total++; if ({bus.Red, bus.Green, bus.Blue} !== 24'hF8A0E0) begin bad++; $display("FAIL hold_rgb got=%h exp=f8a0e0", {bus.Red, bus.Green, bus.Blue}); end
  endtask

  task automatic test_back_to_back();
    bus.wr_en = 1'b1; bus.wr_bank = 2'd0; bus.wr_idx = 4'd3; bus.wr_rgb = 24'h123456;
    bus.pix_valid = 1'b1; bus.pix_bank = 2'd0; bus.pix_idx = 4'd3;
    step();
    bus.wr_en = 1'b0;
    step();
    bus.pix_valid = 1'b0;
    step();
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL rdw_valid0 got=%b exp=1", bus.out_valid); end
    total++; if ({bus.Red, bus.Green, bus.Blue} !== 24'h000000) begin bad++; $display("FAIL rdw_old got=%h exp=000000", {bus.Red, bus.Green, bus.Blue}); end
    step();
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL rdw_valid1 got=%b exp=1", bus.out_valid); end
    total++; if ({bus.Red, bus.Green, bus.Blue} !== 24'h123456) begin bad++; $display("FAIL rdw_new got=%h exp=123456", {bus.Red, bus.Green, bus.Blue}); end
  endtask

  task automatic test_transparency();
    logic [23:0] rgb;
    logic tr, vld;
    lookup(2'd0, 4'd0, rgb, tr, vld);
    total++; if (vld !== 1'b1 || tr !== 1'b1) begin bad++; $display("FAIL tr_b0 got=v%b t%b exp=v1 t1", vld, tr); end
    lookup(2'd2, 4'd0, rgb, tr, vld);
    total++; if (tr !== 1'b1) begin bad++; $display("FAIL tr_b2 got=%b exp=1", tr); end
    lookup(2'd0, 4'd1, rgb, tr, vld);
    total++; if (tr !== 1'b0) begin bad++; $display("FAIL tr_idx1 got=%b exp=0", tr); end
    write(2'd3, 4'd5, 24'hABCDEF);
    lookup(2'd3, 4'd0, rgb, tr, vld);
    total++; if (vld !== 1'b1 || tr !== 1'b0 || rgb !== 24'h000000) begin bad++; $display("FAIL oob_idx0 got=v%b t%b %h exp=v1 t0 000000", vld, tr, rgb); end
    lookup(2'd3, 4'd5, rgb, tr, vld);
    total++; if (rgb !== 24'h000000) begin bad++; $display("FAIL oob_idx5 got=%h exp=000000", rgb); end
    lookup(2'd0, 4'd5, rgb, tr, vld);
    total++; if (rgb !== 24'h000000) begin bad++; $display("FAIL oob_wr_b0 got=%h exp=000000", rgb); end
    lookup(2'd2, 4'd5, rgb, tr, vld);
    total++; if (rgb !== 24'h000000) begin bad++; $display("FAIL oob_wr_b2 got=%h exp=000000", rgb); end
    lookup(2'd1, 4'd5, rgb, tr, vld);
    total++; if (rgb !== 24'hF8A0E0) begin bad++; $display("FAIL oob_wr_b1 got=%h exp=f8a0e0", rgb); end
  endtask

  task automatic test_fade_down();
    logic [23:0] rgb;
    logic tr, vld;
    write(2'd2, 4'd7, 24'hFFFFFF);
    bus.fade_start = 1'b1; bus.fade_dir = 1'b0;
    step();
    bus.fade_start = 1'b0;
    total++; if (bus.fade_busy !== 1'b1 || bus.fade_level !== 4'd8) begin bad++; $display("FAIL fd_start got=b%b l%0d exp=b1 l8", bus.fade_busy, bus.fade_level); end
    ticks(3);
    total++; if (bus.fade_level !== 4'd8) begin bad++; $display("FAIL fd_3ticks got=%0d exp=8", bus.fade_level); end
    ticks(1);
    total++; if (bus.fade_level !== 4'd7) begin bad++; $display("FAIL fd_4ticks got=%0d exp=7", bus.fade_level); end
    lookup(2'd2, 4'd7, rgb, tr, vld);
    total++; if (rgb !== 24'hDFDFDF) begin bad++; $display("FAIL fd_l7_rgb got=%h exp=dfdfdf", rgb); end
    ticks(27);
    total++; if (bus.fade_level !== 4'd1 || bus.fade_busy !== 1'b1) begin bad++; $display("FAIL fd_31ticks got=b%b l%0d exp=b1 l1", bus.fade_busy, bus.fade_level); end
    ticks(1);
    total++; if (bus.fade_level !== 4'd0 || bus.fade_busy !== 1'b0) begin bad++; $display("FAIL fd_done got=b%b l%0d exp=b0 l0", bus.fade_busy, bus.fade_level); end
    lookup(2'd2, 4'd7, rgb, tr, vld);
    total++; if (rgb !== 24'h000000) begin bad++; $display("FAIL fd_l0_rgb got=%h exp=000000", rgb); end
    bus.fade_start = 1'b1; bus.fade_dir = 1'b0;
    step();
    bus.fade_start = 1'b0;
    total++; if (bus.fade_busy !== 1'b0 || bus.fade_level !== 4'd0) begin bad++; $display("FAIL fd_noop got=b%b l%0d exp=b0 l0", bus.fade_busy, bus.fade_level); end
  endtask

  task automatic test_fade_up();
    logic [23:0] rgb;
    logic tr, vld;
    bus.fade_start = 1'b1; bus.fade_dir = 1'b1; bus.frame_tick = 1'b1;
    step();
    bus.fade_start = 1'b0; bus.frame_tick = 1'b0;
    total++; if (bus.fade_busy !== 1'b1 || bus.fade_level !== 4'd0) begin bad++; $display("FAIL fu_start got=b%b l%0d exp=b1 l0", bus.fade_busy, bus.fade_level); end
    ticks(3);
    total++; if (bus.fade_level !== 4'd0) begin bad++; $display("FAIL fu_tick_uncounted got=%0d exp=0", bus.fade_level); end
    ticks(1);
    total++; if (bus.fade_level !== 4'd1) begin bad++; $display("FAIL fu_first_step got=%0d exp=1", bus.fade_level); end
    bus.fade_start = 1'b1; bus.fade_dir = 1'b0;
    step();
    bus.fade_start = 1'b0;
    total++; if (bus.fade_busy !== 1'b1 || bus.fade_level !== 4'd1) begin bad++; $display("FAIL fu_midstart got=b%b l%0d exp=b1 l1", bus.fade_busy, bus.fade_level); end
    ticks(3);
    bus.pix_valid = 1'b1; bus.pix_bank = 2'd2; bus.pix_idx = 4'd7; bus.frame_tick = 1'b1;
    step();
    bus.pix_valid = 1'b0; bus.frame_tick = 1'b0;
    total++; if (bus.fade_level !== 4'd2) begin bad++; $display("FAIL fu_second_step got=%0d exp=2", bus.fade_level); end
    step();
    step();
    total++; if ({bus.Red, bus.Green, bus.Blue} !== 24'h1F1F1F) begin bad++; $display("FAIL fu_level_at_sample got=%h exp=1f1f1f", {bus.Red, bus.Green, bus.Blue}); end
    ticks(23);
    total++; if (bus.fade_level !== 4'd7 || bus.fade_busy !== 1'b1) begin bad++; $display("FAIL fu_almost got=b%b l%0d exp=b1 l7", bus.fade_busy, bus.fade_level); end
    ticks(1);
    total++; if (bus.fade_level !== 4'd8 || bus.fade_busy !== 1'b0) begin bad++; $display("FAIL fu_done got=b%b l%0d exp=b0 l8", bus.fade_busy, bus.fade_level); end
    lookup(2'd2, 4'd7, rgb, tr, vld);
    total++; if (rgb !== 24'hFFFFFF) begin bad++; $display("FAIL fu_l8_rgb got=%h exp=ffffff", rgb); end
  endtask

  task automatic test_reset_mid();
    logic [23:0] rgb;
    logic tr, vld;
    bus.fade_start = 1'b1; bus.fade_dir = 1'b0;
    step();
    bus.fade_start = 1'b0;
    ticks(10);
    total++; if (bus.fade_level !== 4'd6 || bus.fade_busy !== 1'b1) begin bad++; $display("FAIL rm_10ticks got=b%b l%0d exp=b1 l6", bus.fade_busy, bus.fade_level); end
    bus.pix_valid = 1'b1; bus.pix_bank = 2'd1; bus.pix_idx = 4'd5;
    step();
    bus.pix_valid = 1'b0;
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    total++; if (bus.out_valid !== 1'b0 || bus.fade_busy !== 1'b0 || bus.fade_level !== 4'd8) begin bad++; $display("FAIL rm_next got=v%b b%b l%0d exp=v0 b0 l8", bus.out_valid, bus.fade_busy, bus.fade_level); end
    step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rm_aborted_pixel got=%b exp=0", bus.out_valid); end
    lookup(2'd1, 4'd5, rgb, tr, vld);
    total++; if (vld !== 1'b1 || rgb !== 24'h000000) begin bad++; $display("FAIL rm_b1_cleared got=v%b %h exp=v1 000000", vld, rgb); end
    lookup(2'd0, 4'd3, rgb, tr, vld);
    total++; if (rgb !== 24'h000000) begin bad++; $display("FAIL rm_b0_cleared got=%h exp=000000", rgb); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    Reset = 1'b1;
    idle_inputs();
    test_reset();
    test_write_lookup();
    test_back_to_back();
    test_transparency();
    test_fade_down();
    test_fade_up();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
